// File: rtl/mat_bram_pkg.sv
// Shared types, defaults and geometry helpers for the matrix BRAM controller.
// Matrices are stored as NSEG words of SEG_ROWS rows each, addressed {slot, seg}.
package mat_bram_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WR    = 2'd1,
        S_RD    = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam int DEF_DW       = 8;
    localparam int DEF_ROWS     = 16;
    localparam int DEF_COLS     = 128;
    localparam int DEF_SEG_ROWS = 4;
    localparam int DEF_SLOT_AW  = 8;
    localparam int DEF_RD_LAT   = 2;

    function automatic int f_nseg(input int rows, input int seg_rows);
        return rows / seg_rows;
    endfunction

    function automatic int f_seg_w(input int rows, input int seg_rows);
        return $clog2(f_nseg(rows, seg_rows));
    endfunction

    function automatic int f_addr_w(input int slot_aw, input int rows,
                                    input int seg_rows);
        return slot_aw + f_seg_w(rows, seg_rows);
    endfunction

endpackage

// File: rtl/mat_sp_ram.sv
// Single-port RAM, one word per clock, read data delayed RD_LAT clocks.
// Contents are never reset; only enabled read cycles load the read pipe.
module mat_sp_ram #(
    parameter int AW     = 10,
    parameter int DEPTH  = 1024,
    parameter int WW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          I_CLK,
    input  logic          I_EN,
    input  logic          I_WE,
    input  logic [AW-1:0] I_ADDR,
    input  logic [WW-1:0] I_WDATA,
    output logic [WW-1:0] O_RDATA
);

    logic [WW-1:0] r_mem  [DEPTH];
    logic [WW-1:0] r_pipe [RD_LAT];

    // Array write, array read into stage 0, then plain delay stages
    always_ff @(posedge I_CLK) begin
        if (I_EN && I_WE) begin
            r_mem[I_ADDR] <= I_WDATA;
        end
        if (I_EN && !I_WE) begin
            r_pipe[0] <= r_mem[I_ADDR];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign O_RDATA = r_pipe[RD_LAT-1];

endmodule

// File: rtl/mat_bram_ctrl.sv
// Moves whole ROWSxCOLS matrices to/from a segmented single-port RAM.
// Writes stream a snapshot; reads issue back-to-back and capture by latency.
module mat_bram_ctrl
    import mat_bram_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int ROWS     = DEF_ROWS,
    parameter int COLS     = DEF_COLS,
    parameter int SEG_ROWS = DEF_SEG_ROWS,
    parameter int SLOT_AW  = DEF_SLOT_AW,
    parameter int RD_LAT   = DEF_RD_LAT
) (
    input  logic                               I_CLK,
    input  logic                               I_RST_N,
    input  logic                               I_REQ_VLD,
    output logic                               O_REQ_RDY,
    input  logic                               I_REQ_WR,
    input  logic [SLOT_AW-1:0]                 I_SLOT,
    input  logic [ROWS-1:0][COLS-1:0][DW-1:0]  I_MAT,
    output logic [ROWS-1:0][COLS-1:0][DW-1:0]  O_MAT,
    output logic                               O_RD_VLD,
    output logic                               O_WR_DONE,
    output logic                               O_BUSY
);

    localparam int NSEG   = f_nseg(ROWS, SEG_ROWS);
    localparam int SEG_W  = f_seg_w(ROWS, SEG_ROWS);
    localparam int CW     = (SEG_W > 0) ? SEG_W : 1;
    localparam int AW     = f_addr_w(SLOT_AW, ROWS, SEG_ROWS);
    localparam int WORD_W = SEG_ROWS * COLS * DW;
    localparam int MAT_W  = ROWS * COLS * DW;

    if (((ROWS % SEG_ROWS) != 0) || ((NSEG & (NSEG - 1)) != 0)
        || (RD_LAT < 1)) begin : g_bad_cfg
        $error("mat_bram_ctrl: illegal ROWS/SEG_ROWS/RD_LAT combination");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SLOT_AW-1:0] r_slot;
    logic [MAT_W-1:0]   r_snap;
    logic [MAT_W-1:0]   r_mat;
    logic [CW-1:0]      r_iss_cnt;
    logic [CW-1:0]      r_cap_cnt;
    logic [RD_LAT-1:0]  r_vld_pipe;
    logic               r_rd_vld;
    logic               r_wr_done;

    logic               w_accept;
    logic               w_iss_last;
    logic               w_rd_iss;
    logic               w_cap;
    logic               w_cap_last;
    logic               w_ram_en;
    logic               w_ram_we;
    logic [AW-1:0]      w_ram_addr;
    logic [WORD_W-1:0]  w_ram_wdata;
    logic [WORD_W-1:0]  w_ram_rdata;

    assign O_REQ_RDY   = (r_state == S_IDLE);
    assign O_BUSY      = ~O_REQ_RDY;
    assign O_MAT       = r_mat;
    assign O_RD_VLD    = r_rd_vld;
    assign O_WR_DONE   = r_wr_done;

    assign w_accept    = I_REQ_VLD & O_REQ_RDY;
    assign w_iss_last  = (r_iss_cnt == CW'(NSEG - 1));
    assign w_rd_iss    = w_ram_en & ~w_ram_we;
    assign w_cap       = r_vld_pipe[RD_LAT-1];
    assign w_cap_last  = (r_cap_cnt == CW'(NSEG - 1));
    assign w_ram_wdata = r_snap[int'(r_iss_cnt) * WORD_W +: WORD_W];

    if (SEG_W > 0) begin : g_addr_seg
        assign w_ram_addr = {r_slot, r_iss_cnt};
    end else begin : g_addr_slot
        assign w_ram_addr = r_slot;
    end

    // State register
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and RAM strobes; RAM only enabled while issuing
    always_comb begin
        w_state_nxt = r_state;
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (I_REQ_VLD) begin
                    w_state_nxt = I_REQ_WR ? S_WR : S_RD;
                end
            end
            S_WR: begin
                w_ram_en = 1'b1;
                w_ram_we = 1'b1;
                if (w_iss_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                w_ram_en = 1'b1;
                if (w_iss_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_cap && w_cap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snapshot slot and matrix at accept so the requester may move on
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_slot <= '0;
            r_snap <= '0;
        end else if (w_accept) begin
            r_slot <= I_SLOT;
            r_snap <= I_MAT;
        end
    end

    // Issue counter walks segments while the RAM is enabled
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_iss_cnt <= '0;
        end else if (w_ram_en) begin
            r_iss_cnt <= w_iss_last ? '0 : r_iss_cnt + 1'b1;
        end
    end

    // Read-return tracking, independent of the issue side
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_vld_pipe <= '0;
            r_cap_cnt  <= '0;
        end else begin
            r_vld_pipe <= RD_LAT'({r_vld_pipe, w_rd_iss});
            if (w_cap) begin
                r_cap_cnt <= w_cap_last ? '0 : r_cap_cnt + 1'b1;
            end
        end
    end

    // One-cycle completion pulses
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_wr_done <= 1'b0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_wr_done <= w_ram_we & w_iss_last;
            r_rd_vld  <= w_cap & w_cap_last;
        end
    end

    // Output matrix changes only when a read segment returns
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_mat <= '0;
        end else if (w_cap) begin
            r_mat[int'(r_cap_cnt) * WORD_W +: WORD_W] <= w_ram_rdata;
        end
    end

    mat_sp_ram #(
        .AW     (AW),
        .DEPTH  (1 << AW),
        .WW     (WORD_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .I_CLK   (I_CLK),
        .I_EN    (w_ram_en),
        .I_WE    (w_ram_we),
        .I_ADDR  (w_ram_addr),
        .I_WDATA (w_ram_wdata),
        .O_RDATA (w_ram_rdata)
    );

endmodule

// File: doc/mat_bram_ctrl.md
MAT_BRAM_CTRL -- requirements
Module: mat_bram_ctrl

Interface
REQ-001 SHALL have parameter DW, default 8, element width in bits.
REQ-002 SHALL have parameter ROWS, default 16, matrix rows.
REQ-003 SHALL have parameter COLS, default 128, matrix columns.
REQ-004 SHALL have parameter SEG_ROWS, default 4, rows packed per RAM word.
REQ-005 SHALL have parameter SLOT_AW, default 8, matrix slot address width.
REQ-006 SHALL have parameter RD_LAT, default 2, RAM read latency in clocks.
REQ-007 SHALL have port I_CLK, input, 1, clock; reset I_RST_N, asynchronous, active-low; clock I_CLK.
REQ-008 SHALL have port I_RST_N, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port I_REQ_VLD, input, 1, request valid.
REQ-010 SHALL have port O_REQ_RDY, output, 1, controller can accept a request.
REQ-011 SHALL have port I_REQ_WR, input, 1, 1 = write matrix, 0 = read matrix.
REQ-012 SHALL have port I_SLOT, input, SLOT_AW, matrix slot (Q/K/V/line select).
REQ-013 SHALL have port I_MAT, input, [ROWS][COLS] x DW, write data.
REQ-014 SHALL have port O_MAT, output, [ROWS][COLS] x DW, read data.
REQ-015 SHALL have port O_RD_VLD, output, 1, one-cycle pulse: O_MAT complete.
REQ-016 SHALL have port O_WR_DONE, output, 1, one-cycle pulse: write committed.
REQ-017 SHALL have port O_BUSY, output, 1, operation in progress.

Function
REQ-018 SHALL derive NSEG = ROWS/SEG_ROWS, WORD_W = SEG_ROWS*COLS*DW, RAM address = {slot, seg}, width SLOT_AW + clog2(NSEG).
REQ-019 SHALL reject elaboration when ROWS mod SEG_ROWS != 0, NSEG not a power of two, or RD_LAT < 1.
REQ-020 SHALL accept a request on an edge where I_REQ_VLD and O_REQ_RDY are both high; O_REQ_RDY = (state == S_IDLE), O_BUSY = its inverse.
REQ-021 SHALL leave an unaccepted request pending, no drop or preemption; the requester holds I_REQ_VLD/I_REQ_WR/I_SLOT/I_MAT stable until accepted.
REQ-022 SHALL implement FSM states S_IDLE, S_WR, S_RD, S_DRAIN.
- S_IDLE -> S_WR on an accepted write; S_IDLE -> S_RD on an accepted read.
- S_WR -> S_IDLE after segment NSEG-1 is written.
- S_RD -> S_DRAIN after segment NSEG-1 is issued.
- S_DRAIN -> S_IDLE when the last segment is captured.
REQ-023 SHALL snapshot I_SLOT and the full I_MAT at the accept edge E0; later I_MAT changes do not affect the write.
REQ-024 SHALL, on write, write segment k (rows k*SEG_ROWS..k*SEG_ROWS+SEG_ROWS-1; row r at bits [(r*COLS+c)*DW +: DW]) at edge E(1+k), and assert O_WR_DONE in the cycle after E(NSEG); O_REQ_RDY is high in that same cycle.
REQ-025 SHALL, on read, issue segment k address at edge E(1+k), back-to-back with no bubbles, and capture its data into O_MAT rows at edge E(1+k+RD_LAT) via a capture counter independent of the issue counter.
REQ-026 SHALL assert O_RD_VLD for exactly one cycle after E(NSEG+RD_LAT).
REQ-027 SHALL update O_MAT segment-wise during a read only; O_MAT holds its value otherwise, including across writes.
REQ-028 SHALL accept a new request on the edge that ends the done cycle, so a request held pending is accepted at that edge; a write to a slot followed by a read of it returns the written data.
REQ-029 SHALL drive the RAM enable only during issue/write cycles, with write-enable only in S_WR.

Reset
REQ-030 SHALL, on I_RST_N low, asynchronously force: state S_IDLE, counters 0, O_REQ_RDY 1, O_BUSY 0, O_RD_VLD 0, O_WR_DONE 0, O_MAT all zero, RAM enable 0.
REQ-031 SHALL, on reset mid-operation, abort with no done/valid pulse; partially written slot contents are undefined; RAM contents are not cleared.

Structure
REQ-032 SHALL place state enum, default parameter constants and NSEG/address-width helper functions in package mat_bram_pkg.
REQ-033 SHALL instantiate one sub-module mat_sp_ram (single-port RAM, WORD_W wide, RD_LAT-registered output, parameterised depth); no vendor IP in this block.

Verification
REQ-034 SHALL cover: write slot 3 with element value (r*COLS+c) mod 256 -> O_WR_DONE pulses 5 cycles after accept (defaults); then read slot 3 -> O_RD_VLD 7 cycles after accept, O_MAT matches exactly.
REQ-035 SHALL cover: I_REQ_VLD held during a write -> O_REQ_RDY low for 4 cycles; the pending read is accepted in the O_WR_DONE cycle and returns the new data.
REQ-036 SHALL cover: I_MAT changed to all 0xFF one cycle after write accept -> a subsequent read returns the original snapshot.
REQ-037 SHALL cover: reset asserted at cycle 3 of a read -> no O_RD_VLD, O_MAT = 0, O_REQ_RDY = 1 immediately.
REQ-038 SHALL cover: RD_LAT=3, SEG_ROWS=8 build; write/read slots 0 and 255 -> distinct data, O_RD_VLD 6 cycles after accept.
